// File: rtl/mac_tb_pkg.sv
// Shared types and defaults for the MAC result checker.
package mac_tb_pkg;
  localparam int DATA_W_DEF  = 32;
  localparam int NUM_VEC_DEF = 1000;
  localparam int CNT_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chk_state_e;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Registered-occupancy FIFO; a pushed word is visible at dout one cycle later.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       cnt;
  logic              do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/result_checker.sv
// Compares DUT MAC results against buffered expected values over a run of NUM_VEC vectors.
module result_checker
  import mac_tb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_VEC = NUM_VEC_DEF,
  parameter int DEPTH   = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic              exp_valid,
  input  logic [DATA_W-1:0] exp_mac,
  output logic              exp_ready,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_mac,
  output logic              res_ready,
  output logic [15:0]       pass_count,
  output logic [15:0]       err_count,
  output logic [15:0]       first_err_idx,
  output logic [DATA_W-1:0] first_err_got,
  output logic [DATA_W-1:0] first_err_exp,
  output logic              busy,
  output logic              done
);
  chk_state_e        state;
  logic              full, empty, push, pop, enter_run, mismatch;
  logic [DATA_W-1:0] head;
  logic [15:0]       vec_idx;

  assign exp_ready = (state == ST_RUN) && !full;
  assign res_ready = (state == ST_RUN) && !empty;
  assign push      = exp_valid && exp_ready;
  assign pop       = res_valid && res_ready;
  assign enter_run = start && (state != ST_RUN);
  assign mismatch  = (head != res_mac);

  // Flushed on run entry so leftovers from a previous run never get compared.
  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_exp_fifo (
    .clk   (clk),
    .rst   (RST),
    .clr   (enter_run),
    .push  (push),
    .pop   (pop),
    .din   (exp_mac),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      vec_idx       <= '0;
      pass_count    <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_got <= '0;
      first_err_exp <= '0;
    end else if (enter_run) begin
      state         <= ST_RUN;
      busy          <= 1'b1;
      done          <= 1'b0;
      vec_idx       <= '0;
      pass_count    <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_got <= '0;
      first_err_exp <= '0;
    end else if (pop) begin
      vec_idx <= vec_idx + 16'd1;
      if (mismatch) begin
        err_count <= sat_inc(err_count);
        // err_count saturates and never returns to zero, so zero means no mismatch yet.
        if (err_count == '0) begin
          first_err_idx <= vec_idx;
          first_err_got <= res_mac;
          first_err_exp <= head;
        end
      end else begin
        pass_count <= sat_inc(pass_count);
      end
      if (vec_idx == 16'(NUM_VEC - 1)) begin
        state <= ST_DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_result_checker.sv
// Randomized and directed bench for result_checker against a queue-based run model.
module tb_result_checker;
  localparam int DATA_W  = 32;
  localparam int NUM_VEC = 4;
  localparam int DEPTH   = 8;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DONE  = 2;

  logic              clk = 1'b0;
  logic              RST = 1'b1;
  logic              start = 1'b0;
  logic              exp_valid = 1'b0;
  logic [DATA_W-1:0] exp_mac = '0;
  logic              exp_ready;
  logic              res_valid = 1'b0;
  logic [DATA_W-1:0] res_mac = '0;
  logic              res_ready;
  logic [15:0]       pass_count, err_count, first_err_idx;
  logic [DATA_W-1:0] first_err_got, first_err_exp;
  logic              busy, done;

  result_checker #(.DATA_W(DATA_W), .NUM_VEC(NUM_VEC), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .RST           (RST),
    .start         (start),
    .exp_valid     (exp_valid),
    .exp_mac       (exp_mac),
    .exp_ready     (exp_ready),
    .res_valid     (res_valid),
    .res_mac       (res_mac),
    .res_ready     (res_ready),
    .pass_count    (pass_count),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .first_err_got (first_err_got),
    .first_err_exp (first_err_exp),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: run state plus a queue of accepted-but-uncompared expected words.
  int                m_state = M_IDLE;
  logic [DATA_W-1:0] mq[$];
  int                m_idx, m_pass, m_err, m_fidx;
  logic [DATA_W-1:0] m_fgot, m_fexp;
  bit                m_seen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_idx = 0; m_pass = 0; m_err = 0; m_fidx = 0;
    m_fgot = '0; m_fexp = '0; m_seen = 0;
  endtask

  task automatic model_step();
    bit                er, rr;
    logic [DATA_W-1:0] h;
    if (RST) begin
      m_state = M_IDLE;
      model_clear();
    end else if (start && m_state != M_RUN) begin
      m_state = M_RUN;
      model_clear();
    end else if (m_state == M_RUN) begin
      er = (mq.size() < DEPTH);
      rr = (mq.size() > 0);
      if (rr && res_valid) begin
        h = mq.pop_front();
        if (h == res_mac) begin
          if (m_pass < 65535) m_pass++;
        end else begin
          if (!m_seen) begin
            m_fidx = m_idx; m_fgot = res_mac; m_fexp = h; m_seen = 1;
          end
          if (m_err < 65535) m_err++;
        end
        m_idx++;
        if (m_idx == NUM_VEC) m_state = M_DONE;
      end
      if (er && exp_valid) mq.push_back(exp_mac);
    end
  endtask

  task automatic check_all();
    chk("busy", busy, m_state == M_RUN);
    chk("done", done, m_state == M_DONE);
    chk("exp_ready", exp_ready, m_state == M_RUN && mq.size() < DEPTH);
    chk("res_ready", res_ready, m_state == M_RUN && mq.size() > 0);
    chk("pass_count", pass_count, m_pass);
    chk("err_count", err_count, m_err);
    chk("first_err_idx", first_err_idx, m_fidx);
    chk("first_err_got", first_err_got, m_fgot);
    chk("first_err_exp", first_err_exp, m_fexp);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic vec(input bit st, input bit ev, input logic [DATA_W-1:0] em,
                     input bit rv, input logic [DATA_W-1:0] rm);
    start = st; exp_valid = ev; exp_mac = em; res_valid = rv; res_mac = rm;
    cyc();
  endtask

  initial begin
    logic [DATA_W-1:0] ev_tab [4];
    logic [DATA_W-1:0] rv_tab [4];
    int dens;
    ev_tab = '{32'd5, 32'd10, 32'd15, 32'd20};

    // Reset state
    cyc();
    RST = 1'b0;

    // All-match run, results trail expected by one cycle
    vec(1, 0, 0, 0, 0);
    for (int i = 0; i <= 4; i++)
      vec(0, i < 4, (i < 4) ? ev_tab[i % 4] : '0, i > 0, (i > 0) ? ev_tab[(i + 3) % 4] : '0);
    chk("match_done", done, 1'b1);
    chk("match_pass", pass_count, 16'd4);
    chk("match_err", err_count, 16'd0);

    // Two mismatches; start from DONE clears counters
    rv_tab = '{32'd5, 32'd11, 32'd15, 32'd21};
    vec(1, 0, 0, 0, 0);
    chk("restart_busy", busy, 1'b1);
    chk("restart_pass", pass_count, 16'd0);
    for (int i = 0; i <= 4; i++)
      vec(0, i < 4, (i < 4) ? ev_tab[i % 4] : '0, i > 0, (i > 0) ? rv_tab[(i + 3) % 4] : '0);
    chk("mm_err", err_count, 16'd2);
    chk("mm_idx", first_err_idx, 16'd1);
    chk("mm_got", first_err_got, 32'd11);
    chk("mm_exp", first_err_exp, 32'd10);

    // Fill FIFO to DEPTH, then free one slot
    vec(1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) vec(0, 1, 32'(100 + i), 0, 0);
    chk("full_ready", exp_ready, 1'b0);
    vec(0, 0, 0, 1, 32'd100);
    chk("unfull_ready", exp_ready, 1'b1);
    for (int i = 1; i < NUM_VEC; i++) vec(0, 0, 0, 1, 32'(100 + i));
    chk("fill_pass", pass_count, 16'd4);

    // No fall-through: pushed word poppable only on the following cycle
    vec(1, 0, 0, 0, 0);
    start = 0; exp_valid = 1; exp_mac = 32'd77; res_valid = 1; res_mac = 32'd77;
    chk("nofall_rdy0", res_ready, 1'b0);
    cyc();
    exp_valid = 0;
    chk("nofall_rdy1", res_ready, 1'b1);
    cyc();
    chk("nofall_pass", pass_count, 16'd1);
    vec(0, 1, 32'd88, 0, 0);
    vec(0, 0, 0, 1, 32'd88);

    // Mid-run reset, then a fresh run with a start pulse that must be ignored
    RST = 1'b1;
    vec(0, 1, 32'd1, 1, 32'd1);
    RST = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_pass", pass_count, 16'd0);
    vec(1, 0, 0, 0, 0);
    for (int i = 0; i <= 4; i++)
      vec(i == 2, i < 4, (i < 4) ? ev_tab[i % 4] : '0, i > 0, (i > 0) ? ev_tab[(i + 3) % 4] : '0);
    chk("ign_start_pass", pass_count, 16'd4);
    chk("ign_start_done", done, 1'b1);

    // Randomized runs
    for (int r = 0; r < 40; r++) begin
      dens = $urandom_range(1, 3);
      vec(1, 0, 0, 0, 0);
      for (int c = 0; c < 30; c++) begin
        start     = ($urandom % 16 == 0);
        RST       = ($urandom % 80 == 0);
        exp_valid = ($urandom % 4 < 3);
        exp_mac   = ($urandom % 4 == 0) ? $urandom : $urandom_range(0, 3);
        res_valid = ($urandom % 4 < dens);
        res_mac   = $urandom_range(0, 3);
        if (mq.size() > 0 && $urandom % 3 != 0) res_mac = mq[0];
        cyc();
      end
      RST = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
